// File: rtl/puf_ro_meter.sv
// rtl/puf_ro_meter.sv - ring-oscillator PUF meter: counts synchronized RO edges over a window
// and compares channel 0 against channel 1 to produce a response bit.
module puf_ro_meter #(
  parameter int CH         = 2,
  parameter int CNT_W      = 20,
  parameter int WIN_W      = 20,
  parameter int CHAL_W     = 6,
  parameter int SETTLE_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CHAL_W-1:0]     challenge,
  input  logic [WIN_W-1:0]      win_len,
  input  logic [CH-1:0]         ro_in,
  output logic                  ro_en,
  output logic [CHAL_W-1:0]     ro_chal,
  output logic                  busy,
  output logic                  done,
  output logic [CH*CNT_W-1:0]   count,
  output logic [CH-1:0]         sat,
  output logic                  resp,
  output logic                  tie
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, FINISH} state_t;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   win_cnt;
  logic [CH-1:0]      sync1;
  logic [CH-1:0]      sync2;
  logic [CH-1:0]      prev;
  logic [CH-1:0]      sat_w;
  logic [CNT_W-1:0]   cnt [CH];
  logic [CH-1:0]      rise;

  assign rise = sync2 & ~prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      sat_w      <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
      ro_en      <= 1'b0;
      ro_chal    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      sat        <= '0;
      resp       <= 1'b0;
      tie        <= 1'b0;
    end else begin
      sync1 <= ro_in;
      sync2 <= sync1;
      prev  <= sync2;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ro_chal    <= challenge;
            win_q      <= win_len;
            sat_w      <= '0;
            for (int i = 0; i < CH; i++) cnt[i] <= '0;
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
            busy       <= 1'b1;
            ro_en      <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            // A zero-length window skips MEASURE so no edge can ever be counted.
            if (win_q == '0) begin
              ro_en <= 1'b0;
              state <= FINISH;
            end else begin
              win_cnt <= win_q - WIN_W'(1);
              state   <= MEASURE;
            end
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        MEASURE: begin
          for (int i = 0; i < CH; i++) begin
            if (rise[i]) begin
              if (cnt[i] == CNT_MAX) sat_w[i] <= 1'b1;
              else                   cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          if (win_cnt == '0) begin
            ro_en <= 1'b0;
            state <= FINISH;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end
        FINISH: begin
          for (int i = 0; i < CH; i++) count[i*CNT_W +: CNT_W] <= cnt[i];
          sat   <= sat_w;
          resp  <= (cnt[0] > cnt[1]);
          tie   <= (cnt[0] == cnt[1]);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_ro_meter.sv
// tb/tb_puf_ro_meter.sv - directed bench for puf_ro_meter with a timeline-based reference model.
module tb_puf_ro_meter;

  localparam int CH = 3, CNT_W = 4, WIN_W = 20, CHAL_W = 6, S = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [CHAL_W-1:0]   challenge = '0;
  logic [WIN_W-1:0]    win_len = '0;
  logic [CH-1:0]       ro_in = '0;
  logic                ro_en, busy, done, resp, tie;
  logic [CHAL_W-1:0]   ro_chal;
  logic [CH*CNT_W-1:0] count;
  logic [CH-1:0]       sat;

  puf_ro_meter #(.CH(CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .CHAL_W(CHAL_W), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .win_len(win_len),
    .ro_in(ro_in), .ro_en(ro_en), .ro_chal(ro_chal), .busy(busy), .done(done),
    .count(count), .sat(sat), .resp(resp), .tie(tie)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Oscillator stimulus: square waves with per-channel period in clk cycles (0 = static low).
  int per [CH];
  int gcnt = 0;
  always @(negedge clk) begin
    gcnt++;
    for (int c = 0; c < CH; c++)
      ro_in[c] = (per[c] > 0) && ((gcnt % per[c]) < per[c] / 2);
  end

  // Reference model: timeline relative to the accepting edge A; results from sampled history.
  int n = 0, A = -1, mw = 0;
  logic [CHAL_W-1:0] m_chal = '0;
  int m_cnt [CH];
  logic [CH-1:0] m_sat = '0;
  logic m_resp = 1'b0, m_tie = 1'b0;
  logic [CH-1:0] hist [0:8191];

  always begin
    logic e_busy, e_en, e_done;
    int r;
    @(posedge clk);
    n++;
    hist[n] = rst ? '0 : ro_in;
    if (rst) begin
      A = -1; m_chal = '0; m_sat = '0; m_resp = 1'b0; m_tie = 1'b0;
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    end else if (start && (A < 0 || (n - 1 - A) > S + mw)) begin
      A = n; mw = int'(win_len); m_chal = challenge;
    end else if (A >= 0 && n == A + S + mw + 1) begin
      for (int c = 0; c < CH; c++) begin
        r = 0;
        for (int k = A + S; k <= A + S + mw - 1; k++)
          if (hist[k-1][c] && !hist[k-2][c]) r++;
        m_sat[c] = (r > MAXC);
        m_cnt[c] = (r > MAXC) ? MAXC : r;
      end
      m_resp = (m_cnt[0] > m_cnt[1]);
      m_tie  = (m_cnt[0] == m_cnt[1]);
    end
    e_busy = (A >= 0) && (n - A <= S + mw);
    e_en   = (A >= 0) && (n - A <= S + mw - 1);
    e_done = (A >= 0) && (n == A + S + mw + 1);
    #1;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("ro_en", 64'(ro_en), 64'(e_en));
    chk("done", 64'(done), 64'(e_done));
    chk("ro_chal", 64'(ro_chal), 64'(m_chal));
    for (int c = 0; c < CH; c++) chk("count", 64'(count[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
    chk("sat", 64'(sat), 64'(m_sat));
    chk("resp", 64'(resp), 64'(m_resp));
    chk("tie", 64'(tie), 64'(m_tie));
  end

  // Caller is off-edge; returns after the edge that raised done.
  task automatic do_meas(input logic [CHAL_W-1:0] ch, input int win, output int lat);
    challenge = ch; win_len = WIN_W'(win); start = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1; start = 1'b0; lat++;
    end while (!done && lat < 3000);
    if (lat >= 3000) chk("done_timeout", 64'(lat), 64'(0));
  endtask

  function automatic int cnt_of(input int c);
    return int'(count[c*CNT_W +: CNT_W]);
  endfunction

  initial begin
    int lat, nd;
    for (int c = 0; c < CH; c++) begin per[c] = 0; m_cnt[c] = 0; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_count", 64'(count), 64'(0));
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic measurement.
    per[0] = 8; per[1] = 16; per[2] = 6;
    do_meas(6'h15, 64, lat);
    chk("basic_lat", 64'(lat), 64'(S + 66));
    chk_rng("basic_c0", cnt_of(0), 7, 9);
    chk_rng("basic_c1", cnt_of(1), 3, 5);
    chk("basic_resp", 64'(resp), 64'(1));
    chk("basic_tie", 64'(tie), 64'(0));
    repeat (3) @(negedge clk);

    // Saturation.
    per[0] = 4; per[1] = 0; per[2] = 0;
    do_meas(6'h03, 100, lat);
    chk("sat_c0", 64'(cnt_of(0)), 64'(15));
    chk("sat_flags", 64'(sat[1:0]), 64'(2'b01));
    repeat (3) @(negedge clk);

    // Zero window with active oscillators.
    per[0] = 8; per[1] = 8; per[2] = 4;
    do_meas(6'h3F, 0, lat);
    chk("zero_lat", 64'(lat), 64'(S + 2));
    chk("zero_count", 64'(count), 64'(0));
    chk("zero_tie", 64'(tie), 64'(1));
    chk("zero_resp", 64'(resp), 64'(0));
    repeat (3) @(negedge clk);

    // Start while busy: the second request must be ignored.
    per[0] = 8; per[1] = 16; per[2] = 0;
    challenge = 6'h2A; win_len = WIN_W'(40); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (S + 10) @(posedge clk);
    @(negedge clk); challenge = 6'h11; win_len = WIN_W'(5); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_chal", 64'(ro_chal), 64'(6'h2A));
    nd = 0;
    repeat (60) begin @(posedge clk); #1; if (done) nd++; end
    chk("busy_one_done", 64'(nd), 64'(1));
    chk("busy_chal_end", 64'(ro_chal), 64'(6'h2A));

    // Reset mid-MEASURE.
    @(negedge clk);
    do begin
      challenge = 6'h07; win_len = WIN_W'(50); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end while (0);
    repeat (S + 20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ro_en", 64'(ro_en), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (80) begin @(posedge clk); #1; if (done) nd++; end
    chk("rst_no_done", 64'(nd), 64'(0));

    // Back-to-back: second start in the done cycle.
    @(negedge clk);
    per[0] = 8; per[1] = 16; per[2] = 0;
    do_meas(6'h0C, 32, lat);
    chk("b2b_first_resp", 64'(resp), 64'(1));
    per[0] = 16; per[1] = 8;
    do_meas(6'h30, 32, lat);
    chk("b2b_lat", 64'(lat), 64'(S + 34));
    chk("b2b_second_resp", 64'(resp), 64'(0));
    chk_rng("b2b_second_c1", cnt_of(1), 3, 5);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
